// File: rtl/ram_bist_rw.sv
// rtl/ram_bist_rw.sv - write-all/read-all self-checking exerciser around an inferred single-port RAM
// Optional build macro: RAM_BIST_FAULT_INJ_EN (corrupts bit 0 of the last word written in pass 0)
module ram_bist_rw #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 5,
  parameter int                NUM_PASSES = 1,
  parameter logic [DATA_W-1:0] SEED       = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       pass_cnt
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_FLUSH,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [15:0]       pass_idx;
  logic              ram_en;
  logic              ram_we;
  logic              start_acc;
  logic              last_pass;
  logic [DATA_W-1:0] wr_pat;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] exp_data;
  logic              rd_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mismatch;

  logic [DATA_W-1:0] mem [DEPTH];

  // Pattern is address + seed + pass, wrapped to the word width by truncating casts.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [15:0]       p);
    return DATA_W'(a) + SEED + DATA_W'(p);
  endfunction

  assign wr_pat   = pattern(addr, pass_idx);
  assign exp_data = pattern(cmp_addr, pass_idx);
  assign mismatch = rd_vld && (rd_data != exp_data);

  // Pass index is only advanced in NEXT, after the final compare of the pass has retired,
  // so the expected value stays aligned with the delayed compare address.
  assign last_pass = ({1'b0, pass_cnt} + 17'd1) == 17'(NUM_PASSES);

`ifdef RAM_BIST_FAULT_INJ_EN
  assign wdata = wr_pat ^ DATA_W'((pass_idx == 16'd0) && (addr == LAST_ADDR));
`else
  assign wdata = wr_pat;
`endif

  // State register; reset aborts any run immediately.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state RAM/handshake controls.
  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    start_acc = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        busy   = 1'b1;
        ram_en = 1'b1;
        ram_we = 1'b1;
        if (addr == LAST_ADDR) begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        busy   = 1'b1;
        ram_en = 1'b1;
        if (addr == LAST_ADDR) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        busy      = 1'b1;
        state_nxt = S_NEXT;
      end
      S_NEXT: begin
        busy      = 1'b1;
        state_nxt = last_pass ? S_DONE : S_WRITE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Address sweeps 0..DEPTH-1 and wraps naturally between WRITE and READ.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      addr <= '0;
    end else if (start_acc) begin
      addr <= '0;
    end else if (ram_en) begin
      addr <= addr + ADDR_W'(1);
    end
  end

  // Pass bookkeeping: pass_cnt counts completed passes, pass_idx selects the pattern.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pass_cnt <= '0;
      pass_idx <= '0;
    end else if (start_acc) begin
      pass_cnt <= '0;
      pass_idx <= '0;
    end else if (state == S_NEXT) begin
      pass_cnt <= pass_cnt + 16'd1;
      if (!last_pass) begin
        pass_idx <= pass_idx + 16'd1;
      end
    end
  end

  // Inferred BRAM: one-cycle read latency, read-first on write, contents never cleared.
  always_ff @(posedge sys_clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[addr] <= wdata;
      end
      rd_data <= mem[addr];
    end
  end

  // Delay the read strobe and address by one cycle to line up with rd_data.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_vld   <= 1'b0;
      cmp_addr <= '0;
    end else begin
      rd_vld   <= (state == S_READ);
      cmp_addr <= addr;
    end
  end

  // Sticky error status, cleared only by reset or an accepted start.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err            <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (start_acc) begin
      err            <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (mismatch) begin
      err <= 1'b1;
      if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
      if (!err) begin
        first_err_addr <= cmp_addr;
      end
    end
  end

endmodule

// File: tb/tb_ram_bist_rw.sv
// tb/tb_ram_bist_rw.sv - randomized self-checking bench for ram_bist_rw
module tb_ram_bist_rw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start3, start4;

  logic        busy0, done0, err0;
  logic [15:0] err_cnt0, pass_cnt0;
  logic [4:0]  fea0;

  logic        busy3, done3, err3;
  logic [15:0] err_cnt3, pass_cnt3;
  logic [4:0]  fea3;

  logic        busy4, done4, err4;
  logic [15:0] err_cnt4, pass_cnt4;
  logic [5:0]  fea4;

  int checks   = 0;
  int failures = 0;

`ifdef RAM_BIST_FAULT_INJ_EN
  localparam bit FINJ = 1'b1;
`else
  localparam bit FINJ = 1'b0;
`endif

  ram_bist_rw u_dut (
    .sys_clk(clk), .sys_rst(rst), .start(start0), .busy(busy0), .done(done0),
    .err(err0), .err_cnt(err_cnt0), .first_err_addr(fea0), .pass_cnt(pass_cnt0)
  );

  ram_bist_rw #(.NUM_PASSES(3), .SEED(8'hF0)) u_p3 (
    .sys_clk(clk), .sys_rst(rst), .start(start3), .busy(busy3), .done(done3),
    .err(err3), .err_cnt(err_cnt3), .first_err_addr(fea3), .pass_cnt(pass_cnt3)
  );

  ram_bist_rw #(.DATA_W(4), .ADDR_W(6)) u_w4 (
    .sys_clk(clk), .sys_rst(rst), .start(start4), .busy(busy4), .done(done4),
    .err(err4), .err_cnt(err_cnt4), .first_err_addr(fea4), .pass_cnt(pass_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitors: the n-th write of a run must hit address n%DEPTH with the pass-n/DEPTH pattern.
  bit         mon3_on = 1'b0;
  int         wcnt3;
  logic [7:0] p2_a0, p2_a31;
  always @(negedge clk) begin
    if (mon3_on && u_p3.ram_en && u_p3.ram_we) begin
      int a;
      int p;
      logic [7:0] e;
      a = wcnt3 % 32;
      p = wcnt3 / 32;
      e = 8'(a + 'hF0 + p);
      if (FINJ && p == 0 && a == 31) e = e ^ 8'h01;
      check("p3_waddr", 32'(u_p3.addr), 32'(a));
      check("p3_wdata", 32'(u_p3.wdata), 32'(e));
      if (p == 2 && a == 0)  p2_a0  = u_p3.wdata;
      if (p == 2 && a == 31) p2_a31 = u_p3.wdata;
      wcnt3++;
    end
  end

  bit mon4_on = 1'b0;
  int wcnt4;
  always @(negedge clk) begin
    if (mon4_on && u_w4.ram_en && u_w4.ram_we) begin
      logic [3:0] e;
      e = 4'(wcnt4 % 64);
      if (FINJ && wcnt4 == 63) e = e ^ 4'h1;
      check("w4_wdata", 32'(u_w4.wdata), 32'(e));
      wcnt4++;
    end
  end

  // One run of the default instance. mode 0: ncorr random corrupted words, 1: word 7 only,
  // 2: words 7 and 3. rst_at >= 0 aborts the run with a reset after that many cycles.
  task automatic run_main(input int ncorr, input int mode, input int rst_at, input bit spur);
    bit         has  [32];
    bit         mism [32];
    logic [7:0] cval [32];
    int n, nbusy, exp_cnt, exp_first, ndone;
    bit got_done, aborted;
    for (int i = 0; i < 32; i++) begin
      has[i]  = 1'b0;
      cval[i] = '0;
    end
    if (mode >= 1) begin has[7] = 1'b1; cval[7] = 8'hAA; end
    if (mode == 2) begin has[3] = 1'b1; cval[3] = 8'h5C; end
    if (mode == 0) begin
      for (int j = 0; j < ncorr; j++) begin
        int a;
        a = $urandom_range(0, 31);
        has[a]  = 1'b1;
        cval[a] = 8'(a) ^ 8'($urandom_range(1, 255));
      end
    end
    if (rst_at >= 0) begin has[2] = 1'b1; cval[2] = 8'hFF; end
    exp_cnt   = 0;
    exp_first = -1;
    for (int i = 0; i < 32; i++) begin
      mism[i] = has[i] || (FINJ && i == 31);
      if (mism[i]) begin
        exp_cnt++;
        if (exp_first < 0) exp_first = i;
      end
    end
    if (exp_first < 0) exp_first = 0;

    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    check("busy_after_start", busy0, 1);
    n = 0; nbusy = 0; got_done = 0; aborted = 0;
    while (n <= 200) begin
      if (busy0) nbusy++;
      if (done0) begin got_done = 1; break; end
      if (n == 32) begin
        for (int i = 0; i < 32; i++) if (has[i]) u_dut.mem[i] = cval[i];
      end
      if (n == rst_at) begin
        check("err_before_rst", err0, 1);
        rst = 1'b1;
        #1;
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_err_cnt", err_cnt0, 0);
        check("rst_fea", fea0, 0);
        check("rst_pass_cnt", pass_cnt0, 0);
        aborted = 1;
        break;
      end
      start0 = spur && ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
      n++;
    end
    start0 = 1'b0;
    if (aborted) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      ndone = 0;
      for (int c = 0; c < 80; c++) begin
        @(posedge clk);
        #1;
        if (done0 || busy0) ndone++;
      end
      check("no_activity_after_rst", ndone, 0);
      return;
    end
    check("done_seen", got_done, 1);
    if (!got_done) return;
    check("done_latency", n, 66);
    check("busy_cycles", nbusy, 66);
    check("busy_at_done", busy0, 0);
    check("err", err0, (exp_cnt != 0));
    check("err_cnt", err_cnt0, exp_cnt);
    check("first_err_addr", fea0, exp_first);
    check("pass_cnt", pass_cnt0, 1);
    start0 = spur;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    check("done_pulse_width", done0, 0);
    check("start_at_done_ignored", busy0, 0);
    check("err_cnt_hold", err_cnt0, exp_cnt);
    check("pass_cnt_hold", pass_cnt0, 1);
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    start0 = 1'b0;
    start3 = 1'b0;
    start4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_err", err0, 0);
    check("reset_err_cnt", err_cnt0, 0);
    check("reset_fea", fea0, 0);
    check("reset_pass_cnt", pass_cnt0, 0);
    @(negedge clk);
    rst = 1'b0;

    run_main(0, 0, -1, 1'b0);
    run_main(0, 1, -1, 1'b1);
    run_main(0, 2, -1, 1'b1);
    for (int r = 0; r < 4; r++) run_main($urandom_range(1, 6), 0, -1, 1'b1);
    run_main(0, 0, 40, 1'b0);
    run_main(0, 0, -1, 1'b1);

    mon3_on = 1'b1;
    wcnt3   = 0;
    p2_a0   = '0;
    p2_a31  = '0;
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    mon3_on = 1'b0;
    check("p3_done", done3, 1);
    check("p3_latency", n, 198);
    check("p3_pass_cnt", pass_cnt3, 3);
    check("p3_err", err3, FINJ);
    check("p3_err_cnt", err_cnt3, FINJ ? 1 : 0);
    check("p3_fea", fea3, FINJ ? 31 : 0);
    check("p3_writes", wcnt3, 96);
    check("p3_pass2_addr0", p2_a0, 8'hF2);
    check("p3_pass2_addr31", p2_a31, 8'h11);

    mon4_on = 1'b1;
    wcnt4   = 0;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    mon4_on = 1'b0;
    check("w4_done", done4, 1);
    check("w4_latency", n, 130);
    check("w4_pass_cnt", pass_cnt4, 1);
    check("w4_err", err4, FINJ);
    check("w4_err_cnt", err_cnt4, FINJ ? 1 : 0);
    check("w4_fea", fea4, FINJ ? 63 : 0);
    check("w4_writes", wcnt4, 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_bist_rw.md
# ram_bist_rw

Parametrised self-checking read/write exerciser for a single-port synchronous RAM, and the next generation of the team's fixed 32×8 RAM test harness. It wraps an inferred single-port RAM with one-cycle read latency and runs a write-all/read-all sequence for a configurable number of passes. Each pass uses a pass-dependent data pattern, and every read word is compared against the value written. Results (error flag, error count, first failing address, pass count) are presented as status outputs for ILA probing or an upstream controller.

## Interface
- DATA_W, 8: RAM word width, 1..32
- ADDR_W, 5: RAM address width; DEPTH = 2**ADDR_W
- NUM_PASSES, 1: write/read passes per run, 1..65535
- SEED, 0: pattern offset for pass 0, DATA_W bits

- sys_clk  in  1  single clock, rising-edge
- sys_rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle run request; ignored while busy=1
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of run
- err  out  1  sticky: at least one mismatch in the current/last run
- err_cnt  out  16  mismatch count, saturates at 16'hFFFF
- first_err_addr  out  ADDR_W  address of first mismatch in the run; 0 if none
- pass_cnt  out  16  passes completed in the current/last run

## Operation
- The RAM is internal, inferred from a sys_clk-registered array. Read data is available one cycle after the address (BRAM semantics, read-first on write).
- Pattern for pass p at address a: (zero-extended a + SEED + p) mod 2**DATA_W.
- FSM states: IDLE, WRITE, READ, FLUSH, NEXT, DONE.
  - IDLE: on start=1, clear err, err_cnt, first_err_addr and pass_cnt; set the pass index to 0; go to WRITE with the address counter at 0.
  - WRITE: assert en=1 and we=1, write the pattern, increment the address. After address DEPTH-1, wrap the address to 0 and go to READ.
  - READ: assert en=1 and we=0, increment the address. A compare-valid bit and the address are delayed one cycle to align with read data. After address DEPTH-1, go to FLUSH.
  - FLUSH: wait one cycle so the last read is compared, then go to NEXT.
  - NEXT: increment pass_cnt. If pass_cnt reaches NUM_PASSES, go to DONE; otherwise increment the pass index and go to WRITE.
  - DONE: pulse done for one cycle, deassert busy, then go to IDLE.
- Compare: when the delayed valid bit is 1 and read data does not match the expected value:
  - set err;
  - increment err_cnt, holding at 16'hFFFF once saturated;
  - capture first_err_addr only if err was 0 before this cycle.
- Multiple mismatches in consecutive cycles are each counted.
- Status outputs hold their values after DONE until the next accepted start.
- start asserted in the same cycle as done is ignored. It is accepted in IDLE only.
- RAM contents are not cleared by reset or start.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE and all counters reset to 0.
- Asserting sys_rst mid-run aborts the run immediately. No done pulse is generated, and busy drops asynchronously.
- With start sampled high at edge k: busy=1 from k+1, and the first write occurs at edge k+1.
- One pass takes 2*DEPTH+1 cycles plus 1 NEXT cycle. done is high during cycle k + NUM_PASSES*(2*DEPTH+2) + 1.
- Compare latency: a mismatch at address a is reflected in err and err_cnt two edges after that address is presented in READ.

## Configuration
- RAM_BIST_FAULT_INJ_EN defined: during pass 0 only, the write to address DEPTH-1 has bit 0 inverted. Every run therefore reports exactly one mismatch, with err=1, err_cnt=1 and first_err_addr=DEPTH-1. This self-tests the checker.
- Undefined: writes are never corrupted. The injection logic is absent from the netlist.

## Test plan
- Defaults, macro undefined: start pulse → done exactly 66 cycles after start is sampled, busy high for 66 cycles, err=0, err_cnt=0, pass_cnt=1.
- NUM_PASSES=3, SEED=8'hF0, DATA_W=8, ADDR_W=5: start → done after 3*66=198 cycles, pass_cnt=3, err=0. Monitor the pattern: pass 2 writes 8'hF2 at address 0 and 8'h11 at address 31 (wrap).
- Macro defined, NUM_PASSES=2: start → err=1, err_cnt=1, first_err_addr=5'd31; the pass-1 compare is clean.
- Bench forces RAM word 7 to 8'hAA after WRITE in a one-pass run (pattern value 8'h07): err_cnt=1, first_err_addr=7. Additionally forcing word 3 in the same run leaves first_err_addr=3.
- sys_rst pulsed at cycle 40 of a run → all outputs 0 and no done pulse. A new start then runs a full, clean run; start pulses sent while busy=1 have no effect on timing.
- DATA_W=4, ADDR_W=6: the pattern truncates to 4 bits; a one-pass run completes in 130 cycles with err=0.
